// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU opcodes,
// FSM states and the operand magnitude limit.
package calc_pkg;

   // Keypad codes (0-9 are the digits themselves)
   localparam logic [4:0] KEY_ADD = 5'd10;
   localparam logic [4:0] KEY_SUB = 5'd11;
   localparam logic [4:0] KEY_MUL = 5'd12;
   localparam logic [4:0] KEY_DIV = 5'd13;
   localparam logic [4:0] KEY_EQ  = 5'd14;
   localparam logic [4:0] KEY_CLR = 5'd15;
   localparam logic [4:0] KEY_NEG = 5'd16;

   // ALU opcodes
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // Largest magnitude an operand may hold
   localparam int OPERAND_LIMIT = 999;

   typedef enum logic [2:0] {
      ST_ENTER_A,
      ST_ENTER_B,
      ST_ISSUE,
      ST_WAIT,
      ST_SHOW,
      ST_ERR
   } state_t;

   function automatic logic is_digit_key(input logic [4:0] k);
      return k <= 5'd9;
   endfunction

   function automatic logic is_op_key(input logic [4:0] k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

   // Operator key to ALU opcode; non-operator keys map to add (never used)
   function automatic logic [1:0] key_to_op(input logic [4:0] k);
      case (k)
         KEY_SUB: return OP_SUB;
         KEY_MUL: return OP_MUL;
         KEY_DIV: return OP_DIV;
         default: return OP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/calc_operand_entry.sv
// Sign/magnitude digit accumulator for one calculator operand. Clear and
// digit may be asserted together to restart the operand with that digit;
// load replaces the operand with a signed value (used to chain a result).
module calc_operand_entry #(
   parameter int MAX_DIGITS = 3
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               clear_i,
   input  logic               load_en_i,
   input  logic signed [10:0] load_value_i,
   input  logic               digit_en_i,
   input  logic [3:0]         digit_i,
   input  logic               negate_i,
   output logic signed [10:0] value_o
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

   logic [10:0]      mag_q, mag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;

   // Next operand: load wins, otherwise clear then digit then sign toggle
   always_comb begin
      mag_d = mag_q;
      cnt_d = cnt_q;
      neg_d = neg_q;
      if (load_en_i) begin
         neg_d = load_value_i[10];
         mag_d = load_value_i[10] ? 11'(-load_value_i) : load_value_i;
         cnt_d = CNT_MAX;
      end else begin
         if (clear_i) begin
            mag_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
         end
         if (digit_en_i && (cnt_d < CNT_MAX)) begin
            mag_d = mag_d * 11'd10 + {7'd0, digit_i};
            cnt_d = cnt_d + 1'b1;
         end
         if (negate_i) begin
            neg_d = ~neg_d;
         end
      end
   end

   // Operand registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mag_q <= '0;
         cnt_q <= '0;
         neg_q <= 1'b0;
      end else begin
         mag_q <= mag_d;
         cnt_q <= cnt_d;
         neg_q <= neg_d;
      end
   end

   // Negating a zero magnitude still yields zero
   assign value_o = neg_q ? 11'(-mag_q) : mag_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-ALU controller: builds two signed operands from key events,
// strobes the ALU on '=', waits ALU_LAT edges and shows the captured result.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int ALU_LAT    = 1,
   parameter int MAX_DIGITS = 3
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               key_valid,
   input  logic [4:0]         key_code,
   output logic               key_ready,
   output logic signed [10:0] alu_a,
   output logic signed [10:0] alu_b,
   output logic [1:0]         alu_op,
   output logic               alu_strobe,
   input  logic signed [20:0] alu_result,
   output logic signed [20:0] disp_value,
   output logic               disp_err,
   output logic               busy
);

   localparam int WC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(ALU_LAT - 1);
   localparam logic signed [20:0] RES_MAX = 21'(OPERAND_LIMIT);
   localparam logic signed [20:0] RES_MIN = -RES_MAX;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WC_W-1:0]    cnt_q, cnt_d;
   logic signed [20:0] result_q, result_d;

   logic               key_acc;
   logic               result_in_range;
   logic signed [10:0] a_value, b_value;
   logic               a_clear, a_load, a_digit, a_negate;
   logic               b_clear, b_digit, b_negate;

   assign key_ready       = (state_q != ST_ISSUE) && (state_q != ST_WAIT);
   assign key_acc         = key_valid && key_ready;
   assign result_in_range = (result_q >= RES_MIN) && (result_q <= RES_MAX);

   calc_operand_entry #(.MAX_DIGITS(MAX_DIGITS)) u_operand_a (
      .clock        (clock),
      .resetn       (resetn),
      .clear_i      (a_clear),
      .load_en_i    (a_load),
      .load_value_i (result_q[10:0]),
      .digit_en_i   (a_digit),
      .digit_i      (key_code[3:0]),
      .negate_i     (a_negate),
      .value_o      (a_value)
   );

   calc_operand_entry #(.MAX_DIGITS(MAX_DIGITS)) u_operand_b (
      .clock        (clock),
      .resetn       (resetn),
      .clear_i      (b_clear),
      .load_en_i    (1'b0),
      .load_value_i (11'sd0),
      .digit_en_i   (b_digit),
      .digit_i      (key_code[3:0]),
      .negate_i     (b_negate),
      .value_o      (b_value)
   );

   // Next-state, operand control and result capture
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      a_clear  = 1'b0;
      a_load   = 1'b0;
      a_digit  = 1'b0;
      a_negate = 1'b0;
      b_clear  = 1'b0;
      b_digit  = 1'b0;
      b_negate = 1'b0;
      if (key_acc && (key_code == KEY_CLR)) begin
         state_d = ST_ENTER_A;
         op_d    = OP_ADD;
         a_clear = 1'b1;
         b_clear = 1'b1;
      end else begin
         case (state_q)
            ST_ENTER_A: begin
               if (key_acc) begin
                  if (is_digit_key(key_code)) begin
                     a_digit = 1'b1;
                  end else if (key_code == KEY_NEG) begin
                     a_negate = 1'b1;
                  end else if (is_op_key(key_code)) begin
                     op_d    = key_to_op(key_code);
                     b_clear = 1'b1;
                     state_d = ST_ENTER_B;
                  end
               end
            end
            ST_ENTER_B: begin
               if (key_acc) begin
                  if (is_digit_key(key_code)) begin
                     b_digit = 1'b1;
                  end else if (key_code == KEY_NEG) begin
                     b_negate = 1'b1;
                  end else if (is_op_key(key_code)) begin
                     op_d = key_to_op(key_code);
                  end else if (key_code == KEY_EQ) begin
                     // Division by zero never reaches the ALU
                     if ((op_q == OP_DIV) && (b_value == 11'sd0)) begin
                        state_d = ST_ERR;
                     end else begin
                        state_d = ST_ISSUE;
                     end
                  end
               end
            end
            ST_ISSUE: begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
            ST_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  result_d = alu_result;
                  state_d  = ST_SHOW;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_SHOW: begin
               if (key_acc) begin
                  if (is_digit_key(key_code)) begin
                     a_clear = 1'b1;
                     a_digit = 1'b1;
                     b_clear = 1'b1;
                     state_d = ST_ENTER_A;
                  end else if (is_op_key(key_code)) begin
                     if (result_in_range) begin
                        a_load  = 1'b1;
                        b_clear = 1'b1;
                        op_d    = key_to_op(key_code);
                        state_d = ST_ENTER_B;
                     end else begin
                        state_d = ST_ERR;
                     end
                  end
               end
            end
            ST_ERR: begin
               state_d = ST_ERR;
            end
            default: begin
               state_d = ST_ENTER_A;
            end
         endcase
      end
   end

   // Control registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_ENTER_A;
         op_q     <= OP_ADD;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Display source follows the state: operand being entered, result, or blank
   always_comb begin
      disp_value = '0;
      case (state_q)
         ST_ENTER_A: disp_value = {{10{a_value[10]}}, a_value};
         ST_ENTER_B,
         ST_ISSUE,
         ST_WAIT:    disp_value = {{10{b_value[10]}}, b_value};
         ST_SHOW:    disp_value = result_q;
         default:    disp_value = '0;
      endcase
   end

   assign alu_a      = a_value;
   assign alu_b      = b_value;
   assign alu_op     = op_q;
   assign alu_strobe = (state_q == ST_ISSUE);
   assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign disp_err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a one-cycle registered ALU model.
module tb_calc_sequencer;

   logic               clock;
   logic               resetn;
   logic               key_valid;
   logic [4:0]         key_code;
   logic               key_ready;
   logic signed [10:0] alu_a;
   logic signed [10:0] alu_b;
   logic [1:0]         alu_op;
   logic               alu_strobe;
   logic signed [20:0] alu_result = '0;
   logic signed [20:0] disp_value;
   logic               disp_err;
   logic               busy;

   int vectors     = 0;
   int miscompares = 0;
   int strobe_cnt  = 0;
   int strobe_mark;

   logic               alu_poke = 1'b0;
   logic signed [20:0] poke_val = '0;

   calc_sequencer dut (
      .clock      (clock),
      .resetn     (resetn),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_strobe (alu_strobe),
      .alu_result (alu_result),
      .disp_value (disp_value),
      .disp_err   (disp_err),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic signed [20:0] alu_model(input logic signed [10:0] a,
                                                    input logic signed [10:0] b,
                                                    input logic [1:0] op);
      logic signed [20:0] ea, eb;
      ea = a;
      eb = b;
      case (op)
         2'b00:   return ea + eb;
         2'b01:   return ea - eb;
         2'b10:   return ea * eb;
         default: return (eb == 0) ? 21'sd0 : ea / eb;
      endcase
   endfunction

   // ALU result register: one-cycle latency after the strobe edge
   always @(posedge clock) begin
      if (alu_strobe === 1'b1) alu_result <= alu_model(alu_a, alu_b, alu_op);
      else if (alu_poke) alu_result <= poke_val;
   end

   always @(posedge clock) begin
      if (alu_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
   end

   task automatic press(input logic [4:0] code);
      @(negedge clock);
      key_valid = 1'b1;
      key_code  = code;
      @(posedge clock);
      #1;
      key_valid = 1'b0;
      $display("key %0d -> disp=%0d a=%0d b=%0d op=%0d err=%0d busy=%0d",
               code, disp_value, alu_a, alu_b, alu_op, disp_err, busy);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; key_valid = 1'b0; key_code = '0;
      repeat (2) @(posedge clock);
      #1;
      vectors++; if (disp_value !== 21'sd0) begin miscompares++; $display("FAIL rst_disp got=%0d exp=0", disp_value); end
      vectors++; if (key_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b exp=1", key_ready); end
      vectors++; if ({alu_strobe, busy, disp_err, alu_op} !== 5'b0) begin miscompares++; $display("FAIL rst_ctrl got=%b exp=00000", {alu_strobe, busy, disp_err, alu_op}); end
      vectors++; if ({alu_a, alu_b} !== 22'b0) begin miscompares++; $display("FAIL rst_ops got=%0d/%0d exp=0/0", alu_a, alu_b); end
      @(negedge clock);
      resetn = 1'b1;
      step();
   endtask

   task automatic test_add();
      press(5'd1); press(5'd2); press(5'd3); press(5'd10); press(5'd4); press(5'd5);
      vectors++; if (disp_value !== 21'sd45) begin miscompares++; $display("FAIL add_entry_b got=%0d exp=45", disp_value); end
      strobe_mark = strobe_cnt;
      press(5'd14);
      vectors++; if ({alu_strobe, busy, key_ready} !== 3'b110) begin miscompares++; $display("FAIL add_issue got=%b exp=110", {alu_strobe, busy, key_ready}); end
      vectors++; if (alu_a !== 11'sd123 || alu_b !== 11'sd45 || alu_op !== 2'b00) begin miscompares++; $display("FAIL add_ops got=%0d,%0d,%0d exp=123,45,0", alu_a, alu_b, alu_op); end
      step();
      vectors++; if ({alu_strobe, busy} !== 2'b01) begin miscompares++; $display("FAIL add_wait got=%b exp=01", {alu_strobe, busy}); end
      vectors++; if (alu_a !== 11'sd123 || alu_b !== 11'sd45) begin miscompares++; $display("FAIL add_hold got=%0d,%0d exp=123,45", alu_a, alu_b); end
      step();
      vectors++; if (disp_value !== 21'sd168) begin miscompares++; $display("FAIL add_result got=%0d exp=168", disp_value); end
      vectors++; if (busy !== 1'b0 || key_ready !== 1'b1) begin miscompares++; $display("FAIL add_show got=%b%b exp=01", busy, key_ready); end
      vectors++; if (strobe_cnt - strobe_mark !== 1) begin miscompares++; $display("FAIL add_strobes got=%0d exp=1", strobe_cnt - strobe_mark); end
   endtask

   task automatic test_mul_overflow();
      press(5'd9); press(5'd9); press(5'd9); press(5'd9);
      vectors++; if (disp_value !== 21'sd999) begin miscompares++; $display("FAIL mul_digit_drop got=%0d exp=999", disp_value); end
      press(5'd16);
      vectors++; if (disp_value !== -21'sd999) begin miscompares++; $display("FAIL mul_negate got=%0d exp=-999", disp_value); end
      press(5'd12); press(5'd9); press(5'd9); press(5'd9); press(5'd14);
      vectors++; if (alu_a !== -11'sd999 || alu_b !== 11'sd999 || alu_op !== 2'b10) begin miscompares++; $display("FAIL mul_ops got=%0d,%0d,%0d exp=-999,999,2", alu_a, alu_b, alu_op); end
      step(); step();
      vectors++; if (disp_value !== -21'sd998001) begin miscompares++; $display("FAIL mul_result got=%0d exp=-998001", disp_value); end
   endtask

   task automatic test_err_recovery();
      press(5'd10);
      vectors++; if (disp_err !== 1'b1 || disp_value !== 21'sd0) begin miscompares++; $display("FAIL err_enter got=%b,%0d exp=1,0", disp_err, disp_value); end
      press(5'd5);
      vectors++; if (disp_err !== 1'b1 || disp_value !== 21'sd0) begin miscompares++; $display("FAIL err_ignore got=%b,%0d exp=1,0", disp_err, disp_value); end
      press(5'd15);
      vectors++; if (disp_err !== 1'b0 || disp_value !== 21'sd0 || alu_op !== 2'b00 || alu_a !== 11'sd0) begin miscompares++; $display("FAIL err_clear got=%b,%0d,%0d,%0d exp=0,0,0,0", disp_err, disp_value, alu_op, alu_a); end
   endtask

   task automatic test_div_zero();
      strobe_mark = strobe_cnt;
      press(5'd7); press(5'd13); press(5'd0); press(5'd14);
      vectors++; if (disp_err !== 1'b1 || busy !== 1'b0 || alu_strobe !== 1'b0) begin miscompares++; $display("FAIL divz_err got=%b%b%b exp=100", disp_err, busy, alu_strobe); end
      step();
      vectors++; if (strobe_cnt !== strobe_mark) begin miscompares++; $display("FAIL divz_strobe got=%0d exp=%0d", strobe_cnt, strobe_mark); end
      press(5'd15);
   endtask

   task automatic test_show_chain();
      press(5'd8); press(5'd11); press(5'd3); press(5'd14);
      step(); step();
      vectors++; if (disp_value !== 21'sd5) begin miscompares++; $display("FAIL chain_result got=%0d exp=5", disp_value); end
      press(5'd12);
      vectors++; if (alu_a !== 11'sd5 || alu_op !== 2'b10 || disp_value !== 21'sd0 || busy !== 1'b0) begin miscompares++; $display("FAIL chain_load got=%0d,%0d,%0d,%b exp=5,2,0,0", alu_a, alu_op, disp_value, busy); end
      press(5'd4); press(5'd14);
      step(); step();
      vectors++; if (disp_value !== 21'sd20) begin miscompares++; $display("FAIL chain_mul got=%0d exp=20", disp_value); end
   endtask

   task automatic test_wait_clear();
      press(5'd15);
      press(5'd6); press(5'd10); press(5'd2); press(5'd14);
      step();
      @(negedge clock);
      key_valid = 1'b1;
      key_code  = 5'd15;
      vectors++; if (key_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL wait_ready got=%b%b exp=01", key_ready, busy); end
      @(posedge clock);
      #1;
      key_valid = 1'b0;
      $display("clear during WAIT -> disp=%0d a=%0d busy=%0d", disp_value, alu_a, busy);
      vectors++; if (disp_value !== 21'sd8 || alu_a !== 11'sd6) begin miscompares++; $display("FAIL wait_clear_dropped got=%0d,%0d exp=8,6", disp_value, alu_a); end
   endtask

   task automatic test_boundaries();
      press(5'd15);
      press(5'd0); press(5'd0); press(5'd0); press(5'd7);
      vectors++; if (disp_value !== 21'sd0) begin miscompares++; $display("FAIL lead_zeros got=%0d exp=0", disp_value); end
      press(5'd16);
      vectors++; if (disp_value !== 21'sd0 || alu_a !== 11'sd0) begin miscompares++; $display("FAIL neg_zero got=%0d,%0d exp=0,0", disp_value, alu_a); end
      press(5'd15);
      press(5'd4); press(5'd20);
      vectors++; if (disp_value !== 21'sd4) begin miscompares++; $display("FAIL bad_code got=%0d exp=4", disp_value); end
      strobe_mark = strobe_cnt;
      press(5'd14);
      step();
      vectors++; if (busy !== 1'b0 || strobe_cnt !== strobe_mark) begin miscompares++; $display("FAIL eq_in_a got=%b,%0d exp=0,%0d", busy, strobe_cnt, strobe_mark); end
      press(5'd15);
      press(5'd5); press(5'd10); press(5'd11); press(5'd2); press(5'd14);
      vectors++; if (alu_op !== 2'b01) begin miscompares++; $display("FAIL op_replace got=%0d exp=1", alu_op); end
      step(); step();
      vectors++; if (disp_value !== 21'sd3) begin miscompares++; $display("FAIL op_replace_result got=%0d exp=3", disp_value); end
      press(5'd14);
      vectors++; if (disp_value !== 21'sd3 || busy !== 1'b0) begin miscompares++; $display("FAIL eq_in_show got=%0d,%b exp=3,0", disp_value, busy); end
   endtask

   task automatic test_reset_midcompute();
      press(5'd15);
      press(5'd2); press(5'd10); press(5'd3);
      strobe_mark = strobe_cnt;
      press(5'd14);
      resetn = 1'b0;
      #1;
      vectors++; if ({alu_strobe, busy, disp_err, alu_op} !== 5'b0 || disp_value !== 21'sd0) begin miscompares++; $display("FAIL midrst_out got=%b,%0d exp=00000,0", {alu_strobe, busy, disp_err, alu_op}, disp_value); end
      vectors++; if ({alu_a, alu_b} !== 22'b0 || key_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ops got=%0d,%0d,%b exp=0,0,1", alu_a, alu_b, key_ready); end
      poke_val = 21'sd12345;
      alu_poke = 1'b1;
      @(posedge clock);
      #1;
      alu_poke = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) step();
      $display("after mid-compute reset -> disp=%0d busy=%0d alu_result=%0d", disp_value, busy, alu_result);
      vectors++; if (disp_value !== 21'sd0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_nocapture got=%0d,%b exp=0,0", disp_value, busy); end
      vectors++; if (strobe_cnt !== strobe_mark) begin miscompares++; $display("FAIL midrst_strobe got=%0d exp=%0d", strobe_cnt, strobe_mark); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul_overflow();
      test_err_recovery();
      test_div_zero();
      test_show_chain();
      test_wait_clear();
      test_boundaries();
      test_reset_midcompute();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
